// File: rtl/muldiv_sequencer_if.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer_if
// Handshake/data bundle between the EX stage and the iterative RV32M
// multiply/divide sequencer.
//   start      EX -> seq   request, sampled only while the sequencer is idle
//   op         EX -> seq   RISC-V funct3 of the M-extension instruction
//   rs1_value  EX -> seq   operand A (multiplicand / dividend)
//   rs2_value  EX -> seq   operand B (multiplier / divisor)
//   flush      EX -> seq   abort any operation in flight
//   busy       seq -> EX   operation in CALC or DONE
//   stall_req  seq -> EX   hold the pipeline while a result is pending
//   done       seq -> EX   one-cycle pulse, result valid
//   result     seq -> EX   registered result
// -----------------------------------------------------------------------------
interface muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1_value;
  logic [XLEN-1:0] rs2_value;
  logic            flush;
  logic            busy;
  logic            stall_req;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, rs1_value, rs2_value, flush,
    input  busy, stall_req, done, result
  );

  modport slave (
    input  start, op, rs1_value, rs2_value, flush,
    output busy, stall_req, done, result
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Iterative RV32M sequencer: radix-2 shift-add multiply and restoring divide,
// one step per cycle over XLEN cycles. Divide-by-zero and signed overflow
// complete without iterating.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   bus   muldiv_sequencer_if.slave (start/op/operands/flush in,
//         busy/stall_req/done/result out)
// Build option:
//   MULDIV_FAST_MUL_EN  multiply ops use one combinational product and finish
//                       like the divide shortcuts; divides are unchanged.
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  muldiv_sequencer_if.slave bus
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam int X2 = 2 * XLEN;
  localparam logic [CW-1:0]   CNT_START = CW'(XLEN);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(1);
  localparam logic [XLEN-1:0] ALL_ONES  = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_op;
  logic            r_neg_q;   // quotient / product sign
  logic            r_neg_r;   // remainder sign (follows dividend)
  logic [X2-1:0]   r_acc;     // product accumulator, or {remainder, quotient}
  logic [X2-1:0]   r_a;       // shifting multiplicand, or divisor in low half
  logic [XLEN-1:0] r_b;       // multiplier, consumed LSB first
  logic [XLEN-1:0] r_result;

  logic            w_accept;
  logic            w_is_div;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_sa;
  logic            w_sb;
  logic            w_div0;
  logic            w_ovf;
  logic            w_shortcut;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic [XLEN-1:0] w_short_result;
  logic [XLEN:0]   w_div_hi;
  logic [XLEN:0]   w_div_diff;
  logic [X2-1:0]   w_acc_step;
  logic [X2-1:0]   w_prod;
  logic [XLEN-1:0] w_final;
`ifdef MULDIV_FAST_MUL_EN
  logic [X2-1:0]   w_fast_prod;
`endif

  // Two's-complement negate when requested.
  function automatic logic [XLEN-1:0] cond_neg(input logic neg, input logic [XLEN-1:0] v);
    return neg ? (~v + XLEN'(1)) : v;
  endfunction

  // Operand signedness, magnitudes and the no-iteration shortcut results.
  always_comb begin
    w_is_div = bus.op[2];
    if (w_is_div) begin
      w_a_signed = ~bus.op[0];
      w_b_signed = ~bus.op[0];
    end else begin
      // MUL 00 treated unsigned (low half is sign-agnostic), MULH 01 s*s,
      // MULHSU 10 s*u, MULHU 11 u*u.
      w_a_signed = bus.op[1] ^ bus.op[0];
      w_b_signed = (bus.op[1:0] == 2'b01);
    end
    w_sa     = w_a_signed & bus.rs1_value[XLEN-1];
    w_sb     = w_b_signed & bus.rs2_value[XLEN-1];
    w_mag_a  = cond_neg(w_sa, bus.rs1_value);
    w_mag_b  = cond_neg(w_sb, bus.rs2_value);
    w_div0   = w_is_div & (bus.rs2_value == '0);
    w_ovf    = w_is_div & ~bus.op[0] & (bus.rs1_value == INT_MIN) & (bus.rs2_value == ALL_ONES);
    w_accept = (r_state == S_IDLE) & bus.start & ~bus.flush;
`ifdef MULDIV_FAST_MUL_EN
    w_fast_prod = {{XLEN{w_sa}}, bus.rs1_value} * {{XLEN{w_sb}}, bus.rs2_value};
    w_shortcut  = w_div0 | w_ovf | ~w_is_div;
`else
    w_shortcut  = w_div0 | w_ovf;
`endif
    if (w_div0) begin
      w_short_result = bus.op[1] ? bus.rs1_value : ALL_ONES;
    end else if (w_ovf) begin
      w_short_result = bus.op[1] ? XLEN'(0) : INT_MIN;
    end else begin
`ifdef MULDIV_FAST_MUL_EN
      w_short_result = (bus.op[1:0] == 2'b00) ? w_fast_prod[XLEN-1:0] : w_fast_prod[X2-1:XLEN];
`else
      w_short_result = '0;
`endif
    end
  end

  // One multiply or divide iteration, and the final result built from it so
  // the last step and the result write share an edge.
  always_comb begin
    // Restoring divide: shift {rem,quo} left, try subtracting the divisor.
    w_div_hi   = r_acc[X2-1:XLEN-1];
    w_div_diff = w_div_hi - {1'b0, r_a[XLEN-1:0]};
    if (r_op[2]) begin
      if (w_div_diff[XLEN]) begin
        w_acc_step = {w_div_hi[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
      end else begin
        w_acc_step = {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
      end
    end else begin
      if (r_b[0]) begin
        w_acc_step = r_acc + r_a;
      end else begin
        w_acc_step = r_acc;
      end
    end
    w_prod = r_neg_q ? (~w_acc_step + X2'(1)) : w_acc_step;
    case (r_op)
      3'b000:                 w_final = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_final = w_prod[X2-1:XLEN];
      3'b100, 3'b101:         w_final = cond_neg(r_neg_q, w_acc_step[XLEN-1:0]);
      3'b110, 3'b111:         w_final = cond_neg(r_neg_r, w_acc_step[X2-1:XLEN]);
      default:                w_final = '0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic; flush always returns to IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = w_shortcut ? S_DONE : S_CALC;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_CALC: begin
        if (bus.flush) begin
          w_state_next = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_CALC;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.busy      = (r_state == S_CALC) | (r_state == S_DONE);
    bus.done      = (r_state == S_DONE);
    bus.stall_req = w_accept | (r_state == S_CALC);
    bus.result    = r_result;
  end

  // Datapath: operand latch, iteration registers, counter and result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_op     <= 3'b000;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_acc    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else if (bus.flush) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= bus.op;
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_a     <= {XLEN'(0), (w_is_div ? w_mag_b : w_mag_a)};
            r_b     <= w_mag_b;
            r_acc   <= w_is_div ? {XLEN'(0), w_mag_a} : X2'(0);
            if (w_shortcut) begin
              r_cnt    <= '0;
              r_result <= w_short_result;
            end else begin
              r_cnt <= CNT_START;
            end
          end
        end
        S_CALC: begin
          r_acc <= w_acc_step;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt - CW'(1);
          if (!r_op[2]) begin
            r_a <= r_a << 1;
          end
          if (r_cnt == CNT_LAST) begin
            r_result <= w_final;
          end
        end
        S_DONE:  r_cnt <= '0;
        default: r_cnt <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
// Directed, table-driven bench for muldiv_sequencer plus hand-written
// sequences for flush, held start, flush-with-start and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  vec_t vq[$];
  int   lat;
  int   stalls;
  int   cnt;
  logic [31:0] res;
  logic [31:0] last_exp;

  muldiv_sequencer_if #(.XLEN(32)) bus ();

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int l, input string name);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = l; v.name = name;
    vq.push_back(v);
  endtask

  // Issue one op; lat = cycles from the accepting edge to done, stalls = cycles
  // with stall_req high. hold keeps start asserted and scrambles operands.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, output int l, output int st, output logic [31:0] r);
    bit seen;
    seen = 1'b0;
    l = -1;
    r = 32'hxxxx_xxxx;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.rs1_value = a; bus.rs2_value = b;
    #1;
    st = bus.stall_req ? 1 : 0;
    for (int c = 1; c <= 100 && !seen; c++) begin
      @(negedge clk);
      if (hold) begin
        bus.rs1_value = 32'hDEAD_BEEF;
        bus.rs2_value = 32'h0000_0003;
      end else begin
        bus.start = 1'b0;
      end
      #1;
      if (bus.stall_req) st++;
      if (bus.done) begin
        seen = 1'b1;
        l = c;
        r = bus.result;
      end
    end
    bus.start = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 3'b000; bus.rs1_value = 32'h0; bus.rs2_value = 32'h0;
    bus.flush = 1'b0;

    add(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, "MUL 7*-3");
    add(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, "MULHU");
    add(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT, "MULH");
    add(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, "MULHSU");
    add(3'b010, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, MUL_LAT, "MULHSU min*2");
    add(3'b000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, MUL_LAT, "MUL min*-1");
    add(3'b100, 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFA, DIV_LAT, "DIV -20/3");
    add(3'b110, 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFE, DIV_LAT, "REM -20/3");
    add(3'b101, 32'd100,       32'd7,         32'd14,        DIV_LAT, "DIVU 100/7");
    add(3'b111, 32'd100,       32'd7,         32'd2,         DIV_LAT, "REMU 100/7");
    add(3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT, "DIV 7/-2");
    add(3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, DIV_LAT, "REM 7/-2");
    add(3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,       "DIVU 5/0");
    add(3'b110, 32'd5,         32'd0,         32'd5,         1,       "REM 5/0");
    add(3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,       "DIV 5/0");
    add(3'b111, 32'h1234_5678, 32'd0,         32'h1234_5678, 1,       "REMU x/0");
    add(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1,       "REM ovf");
    add(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,       "DIV ovf");

    // Reset state.
    #2;
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset done", {31'd0, bus.done}, 32'd0);
    check("reset stall", {31'd0, bus.stall_req}, 32'd0);
    check("reset result", bus.result, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < vq.size(); i++) begin
      run_op(vq[i].op, vq[i].a, vq[i].b, 1'b0, lat, stalls, res);
      check({vq[i].name, " result"}, res, vq[i].exp);
      check({vq[i].name, " latency"}, 32'(lat), 32'(vq[i].lat));
      check({vq[i].name, " stall cycles"}, 32'(stalls), 32'(vq[i].lat));
      @(negedge clk);
      #1;
      check({vq[i].name, " done width"}, {30'd0, bus.done, bus.busy}, 32'd0);
    end
    last_exp = vq[vq.size()-1].exp;

    // Flush mid-DIV: back to IDLE, no done, result retained.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b101; bus.rs1_value = 32'd100; bus.rs2_value = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check("flush busy", {31'd0, bus.busy}, 32'd0);
    check("flush stall", {31'd0, bus.stall_req}, 32'd0);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (bus.done) cnt++;
    end
    check("flush no done", 32'(cnt), 32'd0);
    check("flush result kept", bus.result, last_exp);

    // Flush together with start in IDLE: not accepted.
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'b101; bus.rs1_value = 32'd9; bus.rs2_value = 32'd0;
    #1;
    check("flush+start stall", {31'd0, bus.stall_req}, 32'd0);
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    #1;
    check("flush+start busy", {31'd0, bus.busy}, 32'd0);
    check("flush+start result", bus.result, last_exp);

    // Start held through CALC and DONE with scrambled operands: one op only.
    run_op(3'b101, 32'd100, 32'd7, 1'b1, lat, stalls, res);
    check("held start result", res, 32'd14);
    check("held start latency", 32'(lat), 32'd33);
    cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      if (bus.busy) cnt++;
    end
    check("held start not requeued", 32'(cnt), 32'd0);

    // Reset mid-CALC: immediate reset values, no done afterwards.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b100; bus.rs1_value = 32'd1000; bus.rs2_value = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid reset busy", {31'd0, bus.busy}, 32'd0);
    check("mid reset done", {31'd0, bus.done}, 32'd0);
    check("mid reset result", bus.result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (bus.done) cnt++;
    end
    check("mid reset no done", 32'(cnt), 32'd0);

    // MUL 6*7 after reset, then a back-to-back op with a single idle cycle.
    run_op(3'b000, 32'd6, 32'd7, 1'b0, lat, stalls, res);
    check("MUL 6*7 result", res, 32'd42);
    check("MUL 6*7 latency", 32'(lat), 32'(MUL_LAT));
    run_op(3'b111, 32'd43, 32'd5, 1'b0, lat, stalls, res);
    check("b2b REMU result", res, 32'd3);
    check("b2b REMU latency", 32'(lat), 32'(DIV_LAT));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
